cla_adder_pipelined: RTL
========================

# cla_adder_pipelined

Parametrised, pipelined carry-lookahead adder/subtractor for the miniRISC ALU datapath. It generalises the fixed 16-bit CLA to any WIDTH that is a multiple of GROUP. It adds subtract and carry-chained modes, NZCV-style flags, a register stage per GROUP-bit slice, and a valid/ready handshake on both sides. Each GROUP slice is built from 4-bit augmented CLAs plus a lookahead carry unit. The carry between slices is registered, so throughput is one operation per cycle at any width.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of GROUP.
- GROUP, 16, bits per pipeline slice; must be a multiple of 4.
- NSLICE, WIDTH/GROUP (derived, not overridable), number of slices, equal to the latency in cycles.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block accepts a beat this cycle.
- in1  in  WIDTH  operand A.
- in2  in  WIDTH  operand B.
- c_in  in  1  carry input; used only by ADC and SBB.
- op  in  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- c_out  out  1  carry out of the MSB. For SUB/SBB, 1 means no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.
- neg  out  1  sum[WIDTH-1].

## Operation
- Effective B operand: B' = op[1] ? ~in2 : in2.
- Effective carry in: ADD 0, ADC c_in, SUB 1, SBB c_in.
- Result: {c_out, sum} = in1 + B' + cin_eff, computed modulo 2^WIDTH with c_out as bit WIDTH.
- ovf = (in1[MSB] == B'[MSB]) && (sum[MSB] != in1[MSB]).
- Slice k (0 = LSBs) adds bits [k*GROUP +: GROUP] using the carry registered from slice k-1. Slice 0 uses cin_eff.
- Operand skew: the bits of a beat that belong to slice k are delayed by k register stages so they meet their incoming carry. Sum bits of slices already computed are delayed so that the whole result aligns at the output.
- Pipeline registers: stage k holds a valid bit, the partial sum, the carry, and the operand bits still pending. The final stage drives sum, c_out, ovf, zero and neg directly from registers; there is no combinational path from inputs to outputs.
- Flags zero, neg and ovf are computed in the last slice from the aligned full result and the registered MSBs.
- Flow control uses a single global advance: adv = ~out_valid | out_ready.
  - in_ready = adv.
  - When adv is 1, every stage shifts by one position. A beat is loaded only if in_valid & in_ready; otherwise a bubble (valid = 0) enters.
  - When adv is 0, all stages hold. This is the only backpressure; there is no skid buffer.
- Bubbles propagate; there is no bubble collapsing.
- Beats are never dropped, duplicated or reordered.
- in1, in2, op and c_in are sampled only on an accepted beat; their values are ignored otherwise.

## Timing
- Reset state (asynchronous, immediate): all stage valid bits are 0; out_valid=0; sum=0; c_out=0; ovf=0; zero=0; neg=0. in_ready=1 as soon as rst is released.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+NSLICE-1. With the defaults, a beat accepted at cycle 0 is valid at the output in cycle 2.
- Throughput: one beat per cycle while out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, sum and all flags hold constant.
- Handshake corner: an output beat presented with out_ready=1 and a new input on the same cycle is retired and accepted on that same edge.
- Degenerate case: WIDTH == GROUP gives NSLICE=1 and a single registered stage.
- Reset mid-operation: all in-flight beats are discarded. There is no output activity until new beats are accepted.
- No carry from one beat leaks into the next beat; each beat's carry chain is self-contained.

## Test plan
- Reset: assert rst asynchronously mid-cycle with 2 beats in flight. Required: out_valid=0, sum=0, all flags 0 immediately, in_ready=1 after release, and no stale beat ever emerges.
- ADD carry crossing a slice: 0x0000FFFF + 0x00000001, accepted in cycle 0. Required: in cycle 2, sum=0x00010000, c_out=0, ovf=0, zero=0, neg=0.
- SUB overflow: 0x80000000 SUB 0x00000001. Required: sum=0x7FFFFFFF, c_out=1, ovf=1, neg=0.
- ADC wrap: 0xFFFFFFFF ADC 0x00000000 with c_in=1. Required: sum=0, c_out=1, zero=1, ovf=0.
- SBB borrow: 0x00000000 SBB 0x00000000 with c_in=0. Required: sum=0xFFFFFFFF, c_out=0, neg=1, ovf=0.
- Backpressure and ordering: drive 6 back-to-back random beats and hold out_ready=0 for 3 cycles mid-stream. Required: in_ready=0 exactly while out_valid & ~out_ready, outputs stay stable during the stall, all 6 results emerge in order and match a reference model, and 100 further random beats also match.

Source files
------------

// File: rtl/cla_adder_pipelined.sv
// rtl/cla_adder_pipelined.sv - pipelined carry-lookahead adder/subtractor with NZCV flags
// Each GROUP-bit slice gets its own register stage; slice carries are registered.
module cla_adder_pipelined #(
    parameter int WIDTH = 32,
    parameter int GROUP = 16,
    localparam int NSLICE = WIDTH / GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    // 4-bit augmented CLA blocks chained through a block-level lookahead carry unit
    function automatic logic [GROUP:0] cla_slice(input logic [GROUP-1:0] a,
                                                 input logic [GROUP-1:0] b,
                                                 input logic             cin);
        logic [GROUP-1:0]   g;
        logic [GROUP-1:0]   p;
        logic [GROUP:0]     c;
        logic [GROUP/4:0]   bc;
        logic               bg;
        logic               bp;
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        bc    = '0;
        bc[0] = cin;
        for (int j = 0; j < GROUP/4; j++) begin
            bg = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            bp = &p[4*j +: 4];
            bc[j+1] = bg | (bp & bc[j]);
            c[4*j]  = bc[j];
            for (int i = 1; i < 4; i++) begin
                c[4*j+i] = g[4*j+i-1] | (p[4*j+i-1] & c[4*j+i-1]);
            end
        end
        c[GROUP] = bc[GROUP/4];
        return {c[GROUP], p ^ c[GROUP-1:0]};
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_beff;
    logic             w_cin_eff;

    assign w_adv     = ~out_valid | out_ready;
    assign in_ready  = w_adv;
    assign w_beff    = op[1] ? ~in2 : in2;
    assign w_cin_eff = op[0] ? c_in : op[1];

    genvar k;
    generate
        for (k = 0; k < NSLICE; k++) begin : g_stage
            localparam int LO = k * GROUP;
            localparam int HI = LO + GROUP;

            logic [GROUP-1:0] w_a;
            logic [GROUP-1:0] w_b;
            logic [GROUP-1:0] w_s;
            logic             w_cin;
            logic             w_cout;
            logic             w_vin;
            logic [HI-1:0]    w_full;
            logic             r_valid;
            logic             r_c;
            logic [HI-1:0]    r_s;

            if (k == 0) begin : g_src
                assign w_a    = in1[GROUP-1:0];
                assign w_b    = w_beff[GROUP-1:0];
                assign w_cin  = w_cin_eff;
                assign w_vin  = in_valid;
                assign w_full = w_s;
            end else begin : g_src
                assign w_a    = g_stage[k-1].g_pend.r_pa[GROUP-1:0];
                assign w_b    = g_stage[k-1].g_pend.r_pb[GROUP-1:0];
                assign w_cin  = g_stage[k-1].r_c;
                assign w_vin  = g_stage[k-1].r_valid;
                assign w_full = {w_s, g_stage[k-1].r_s};
            end

            assign {w_cout, w_s} = cla_slice(w_a, w_b, w_cin);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_c     <= 1'b0;
                    r_s     <= '0;
                end else if (w_adv) begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_c <= w_cout;
                        r_s <= w_full;
                    end
                end
            end

            if (k < NSLICE-1) begin : g_pend
                // operand bits of higher slices, skewed until their carry arrives
                logic [WIDTH-HI-1:0] w_pa;
                logic [WIDTH-HI-1:0] w_pb;
                logic [WIDTH-HI-1:0] r_pa;
                logic [WIDTH-HI-1:0] r_pb;

                if (k == 0) begin : g_in
                    assign w_pa = in1[WIDTH-1:HI];
                    assign w_pb = w_beff[WIDTH-1:HI];
                end else begin : g_in
                    assign w_pa = g_stage[k-1].g_pend.r_pa[WIDTH-LO-1:GROUP];
                    assign w_pb = g_stage[k-1].g_pend.r_pb[WIDTH-LO-1:GROUP];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_pa <= '0;
                        r_pb <= '0;
                    end else if (w_adv && w_vin) begin
                        r_pa <= w_pa;
                        r_pb <= w_pb;
                    end
                end
            end else begin : g_flags
                logic r_ovf;
                logic r_zero;
                logic r_neg;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b0;
                        r_neg  <= 1'b0;
                    end else if (w_adv && w_vin) begin
                        r_ovf  <= (w_a[GROUP-1] == w_b[GROUP-1]) && (w_s[GROUP-1] != w_a[GROUP-1]);
                        r_zero <= (w_full == '0);
                        r_neg  <= w_s[GROUP-1];
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_stage[NSLICE-1].r_valid;
    assign sum       = g_stage[NSLICE-1].r_s;
    assign c_out     = g_stage[NSLICE-1].r_c;
    assign ovf       = g_stage[NSLICE-1].g_flags.r_ovf;
    assign zero      = g_stage[NSLICE-1].g_flags.r_zero;
    assign neg       = g_stage[NSLICE-1].g_flags.r_neg;

endmodule
